cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 register file and exception/ERET sequencer for the 5-stage MIPS pipeline.
- Sits at the MEM stage and produces the redirect code `cp0_forward` and the target `pc_cp0`, which the next-PC mux consumes.
- Code `2'b11` means jump to the exception entry; code `2'b01` means return to EPC.
- Holds Status, Cause, EPC and PRId, services mtc0/mfc0, and synchronises six hardware interrupt lines.

---
 rtl/cp0_exc_ctrl.sv | 152 +++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 register file (Status, Cause, EPC, PRId) and exception/ERET sequencer
// for the MEM stage; produces the next-PC redirect code and return target.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] pc_mem,
   input  logic        mem_valid,
   input  logic        exc_req,
   input  logic [4:0]  exc_code_in,
   input  logic        eret,
   input  logic        mtc0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic [5:0]  hw_int,
   output logic [31:0] cp0_rdata,
   output logic [1:0]  cp0_forward,
   output logic [29:0] pc_cp0,
   output logic        exl
);

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } state_e;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;
   localparam logic [4:0] REG_PRID   = 5'd15;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_ERET = 2'b01;
   localparam logic [1:0] FWD_EXC  = 2'b11;

   state_e      state_q, state_d;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [29:0] epc_q, epc_d;
   logic [5:0]  sync_q [SYNC_STAGES];

   logic [5:0]  ip;
   logic        int_pending;
   logic        take_int;
   logic        take_exc;
   logic        take_eret;
   logic        do_mtc0;

   // The last synchroniser stage is Cause.IP itself; there is no extra register.
   assign ip  = sync_q[SYNC_STAGES-1];
   assign exl = (state_q == ST_HANDLER);

   // NOTE: state is written only with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, matching real hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= hw_int;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Priority chain: interrupt > exc_req > eret > mtc0; nothing happens on a bubble.
   assign int_pending = ie_q & ~exl & (|(ip & im_q));
   assign take_int    = mem_valid & int_pending;
   assign take_exc    = mem_valid & ~int_pending & exc_req;
   assign take_eret   = mem_valid & ~int_pending & ~exc_req & eret & exl;
   assign do_mtc0     = mem_valid & ~int_pending & ~exc_req & ~eret & mtc0_we;

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      im_d        = im_q;
      ie_d        = ie_q;
      exc_code_d  = exc_code_q;
      epc_d       = epc_q;
      cp0_forward = FWD_NONE;

      unique case (state_q)
         ST_NORMAL: begin
            if (take_int || take_exc) begin
               cp0_forward = FWD_EXC;
               state_d     = ST_HANDLER;
               epc_d       = pc_mem;
               exc_code_d  = take_int ? 5'd0 : exc_code_in;
            end
         end
         ST_HANDLER: begin
            // A nested exception keeps the original return address.
            if (take_exc) begin
               cp0_forward = FWD_EXC;
               exc_code_d  = exc_code_in;
            end else if (take_eret) begin
               cp0_forward = FWD_ERET;
               state_d     = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase

      if (do_mtc0) begin
         unique case (cp0_addr)
            REG_STATUS: begin
               im_d    = cp0_wdata[15:10];
               ie_d    = cp0_wdata[0];
               state_d = cp0_wdata[1] ? ST_HANDLER : ST_NORMAL;
            end
            REG_EPC: epc_d = cp0_wdata[31:2];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_NORMAL;
         im_q       <= '0;
         ie_q       <= 1'b0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         im_q       <= im_d;
         ie_q       <= ie_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      unique case (cp0_addr)
         REG_STATUS: cp0_rdata = {16'd0, im_q, 8'd0, exl, ie_q};
         REG_CAUSE:  cp0_rdata = {16'd0, ip, 3'd0, exc_code_q, 2'b00};
         REG_EPC:    cp0_rdata = {epc_q, 2'b00};
         REG_PRID:   cp0_rdata = PRID_VALUE;
         default:    cp0_rdata = '0;
      endcase
   end

   assign pc_cp0 = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus random traffic compared
// against a rule-level model of the CP0 registers and hw_int delay line.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h0001_8000;
   localparam int          SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] pc_mem = '0;
   logic        mem_valid = 1'b0;
   logic        exc_req = 1'b0;
   logic [4:0]  exc_code_in = '0;
   logic        eret = 1'b0;
   logic        mtc0_we = 1'b0;
   logic [4:0]  cp0_addr = '0;
   logic [31:0] cp0_wdata = '0;
   logic [5:0]  hw_int = '0;
   logic [31:0] cp0_rdata;
   logic [1:0]  cp0_forward;
   logic [29:0] pc_cp0;
   logic        exl;

   int checks = 0;
   int errors = 0;

   // Reference state: plain register values plus a history of hw_int samples.
   logic [5:0]  m_im;
   logic        m_ie;
   logic        m_exl;
   logic [4:0]  m_code;
   logic [31:0] m_epc;
   logic [5:0]  m_hist[$];

   cp0_exc_ctrl #(.PRID_VALUE(PRID), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .pc_mem(pc_mem), .mem_valid(mem_valid),
      .exc_req(exc_req), .exc_code_in(exc_code_in), .eret(eret),
      .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
      .hw_int(hw_int), .cp0_rdata(cp0_rdata), .cp0_forward(cp0_forward),
      .pc_cp0(pc_cp0), .exl(exl)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] m_ip();
      return (m_hist.size() == SYNC) ? m_hist[0] : 6'd0;
   endfunction

   function automatic logic m_pend();
      return m_ie && !m_exl && ((m_ip() & m_im) != 6'd0);
   endfunction

   function automatic logic [1:0] m_fwd();
      if (!mem_valid) return 2'b00;
      if (m_pend() || exc_req) return 2'b11;
      if (eret && m_exl) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
         5'd13:   return (32'(m_ip()) << 10) | (32'(m_code) << 2);
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_code = '0; m_epc = '0;
      m_hist.delete();
   endtask

   task automatic drive(input logic mv, input logic ex, input logic [4:0] code,
                        input logic er, input logic we, input logic [4:0] a,
                        input logic [31:0] wd, input logic [29:0] pc);
      mem_valid = mv; exc_req = ex; exc_code_in = code; eret = er;
      mtc0_we = we; cp0_addr = a; cp0_wdata = wd; pc_mem = pc;
   endtask

   // Advance one clock edge and apply the architectural rules to the model.
   task automatic tick();
      logic pend;
      logic [5:0] hw;
      pend = m_pend();
      hw   = hw_int;
      @(posedge clk);
      if (rst_n) begin
         if (mem_valid) begin
            if (pend) begin
               m_epc = {pc_mem, 2'b00}; m_exl = 1'b1; m_code = 5'd0;
            end else if (exc_req) begin
               if (!m_exl) begin
                  m_epc = {pc_mem, 2'b00}; m_exl = 1'b1;
               end
               m_code = exc_code_in;
            end else if (eret) begin
               m_exl = 1'b0;
            end else if (mtc0_we) begin
               if (cp0_addr == 5'd12) begin
                  m_im = cp0_wdata[15:10]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
               end else if (cp0_addr == 5'd14) begin
                  m_epc = {cp0_wdata[31:2], 2'b00};
               end
            end
         end
         m_hist.push_back(hw);
         if (m_hist.size() > SYNC) void'(m_hist.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++; if (cp0_forward !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b exp 00", cp0_forward); end
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL rst_exl got %b exp 0", exl); end
      checks++; if (pc_cp0 !== 30'd0) begin errors++; $display("FAIL rst_pc_cp0 got %h exp 0", pc_cp0); end
      for (int a = 12; a <= 14; a++) begin
         cp0_addr = 5'(a); #1;
         checks++; if (cp0_rdata !== 32'd0) begin errors++; $display("FAIL rst_reg%0d got %h exp 0", a, cp0_rdata); end
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      // Enter the handler with EPC = 0x100, then reset asynchronously mid-cycle.
      drive(1, 1, 5'd4, 0, 0, 5'd0, 32'd0, 30'h40);
      #1 tick();
      drive(1, 0, 5'd0, 1, 0, 5'd14, 32'd0, 30'd0);
      #1;
      checks++; if (cp0_forward !== 2'b01) begin errors++; $display("FAIL prerst_fwd got %b exp 01", cp0_forward); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL async_rst_exl got %b exp 0", exl); end
      checks++; if (cp0_forward !== 2'b00) begin errors++; $display("FAIL async_rst_fwd got %b exp 00", cp0_forward); end
      checks++; if (cp0_rdata !== 32'd0) begin errors++; $display("FAIL async_rst_epc got %h exp 0", cp0_rdata); end
      model_reset();
      tick();
      rst_n = 1'b1;
      drive(0, 0, 5'd0, 0, 0, 5'd0, 32'd0, 30'd0);
   endtask

   task automatic test_exception();
      drive(1, 1, 5'd12, 0, 0, 5'd14, 32'd0, 30'h10);
      #1;
      checks++; if (cp0_forward !== 2'b11) begin errors++; $display("FAIL exc_fwd got %b exp 11", cp0_forward); end
      tick();
      drive(0, 0, 5'd0, 0, 0, 5'd14, 32'd0, 30'd0);
      #1;
      checks++; if (cp0_rdata !== 32'h40) begin errors++; $display("FAIL exc_epc got %h exp 40", cp0_rdata); end
      checks++; if (exl !== 1'b1) begin errors++; $display("FAIL exc_exl got %b exp 1", exl); end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata[6:2] !== 5'd12) begin errors++; $display("FAIL exc_code got %0d exp 12", cp0_rdata[6:2]); end
      tick();
   endtask

   task automatic test_interrupt();
      // Writing Status also clears EXL, leaving the handler from the previous test.
      drive(1, 0, 5'd0, 0, 1, 5'd12, 32'h0000_0401, 30'd0);
      #1 tick();
      drive(1, 0, 5'd0, 0, 0, 5'd12, 32'd0, 30'h33);
      #1;
      checks++; if (cp0_rdata !== 32'h401) begin errors++; $display("FAIL int_status got %h exp 401", cp0_rdata); end
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL int_exl0 got %b exp 0", exl); end
      hw_int = 6'h01;
      for (int k = 0; k <= SYNC; k++) begin
         #1;
         checks++;
         if (cp0_forward !== ((k == SYNC) ? 2'b11 : 2'b00)) begin
            errors++; $display("FAIL int_latency cycle %0d got %b exp %b", k, cp0_forward, (k == SYNC) ? 2'b11 : 2'b00);
         end
         tick();
      end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h exp 400", cp0_rdata); end
      checks++; if (exl !== 1'b1) begin errors++; $display("FAIL int_exl1 got %b exp 1", exl); end
      cp0_addr = 5'd14; #1;
      checks++; if (cp0_rdata !== 32'hCC) begin errors++; $display("FAIL int_epc got %h exp cc", cp0_rdata); end
      hw_int = 6'h03;
      tick();
      #1;
      checks++; if (cp0_forward !== 2'b00) begin errors++; $display("FAIL int_masked got %b exp 00", cp0_forward); end
      hw_int = 6'h00;
      drive(1, 0, 5'd0, 0, 1, 5'd12, 32'd0, 30'd0);
      #1 tick();
      drive(0, 0, 5'd0, 0, 0, 5'd0, 32'd0, 30'd0);
      for (int k = 0; k < SYNC; k++) tick();
      #1;
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL int_exit got %b exp 0", exl); end
   endtask

   task automatic test_eret();
      drive(1, 1, 5'd3, 0, 0, 5'd0, 32'd0, 30'h11);
      #1 tick();
      drive(1, 0, 5'd0, 1, 0, 5'd0, 32'd0, 30'd0);
      #1;
      checks++; if (cp0_forward !== 2'b01) begin errors++; $display("FAIL eret_fwd got %b exp 01", cp0_forward); end
      checks++; if (pc_cp0 !== 30'h11) begin errors++; $display("FAIL eret_pc got %h exp 11", pc_cp0); end
      tick();
      #1;
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL eret_exl got %b exp 0", exl); end
      checks++; if (cp0_forward !== 2'b00) begin errors++; $display("FAIL eret_nop got %b exp 00", cp0_forward); end
      tick();
      #1;
      checks++; if (exl !== 1'b0) begin errors++; $display("FAIL eret_nop_exl got %b exp 0", exl); end
   endtask

   task automatic test_exc_priority();
      drive(1, 1, 5'd9, 0, 1, 5'd14, 32'hDEAD_BEEC, 30'h20);
      #1;
      checks++; if (cp0_forward !== 2'b11) begin errors++; $display("FAIL prio_fwd got %b exp 11", cp0_forward); end
      tick();
      drive(0, 1, 5'd2, 0, 0, 5'd14, 32'd0, 30'h7);
      #1;
      checks++; if (cp0_rdata !== 32'h80) begin errors++; $display("FAIL prio_epc got %h exp 80", cp0_rdata); end
      checks++; if (cp0_forward !== 2'b00) begin errors++; $display("FAIL bubble_fwd got %b exp 00", cp0_forward); end
      tick();
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata[6:2] !== 5'd9) begin errors++; $display("FAIL bubble_code got %0d exp 9", cp0_rdata[6:2]); end
      drive(1, 1, 5'd10, 0, 0, 5'd14, 32'd0, 30'h3F);
      #1;
      checks++; if (cp0_forward !== 2'b11) begin errors++; $display("FAIL nested_fwd got %b exp 11", cp0_forward); end
      tick();
      drive(0, 0, 5'd0, 0, 0, 5'd14, 32'd0, 30'd0);
      #1;
      checks++; if (cp0_rdata !== 32'h80) begin errors++; $display("FAIL nested_epc got %h exp 80", cp0_rdata); end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata[6:2] !== 5'd10) begin errors++; $display("FAIL nested_code got %0d exp 10", cp0_rdata[6:2]); end
      checks++; if (exl !== 1'b1) begin errors++; $display("FAIL nested_exl got %b exp 1", exl); end
   endtask

   task automatic test_mtc0_eret();
      drive(1, 0, 5'd0, 0, 1, 5'd14, 32'h0000_0200, 30'd0);
      #1;
      checks++; if (pc_cp0 !== 30'h20) begin errors++; $display("FAIL mtc0_nobypass got %h exp 20", pc_cp0); end
      tick();
      drive(1, 0, 5'd0, 1, 0, 5'd0, 32'd0, 30'd0);
      #1;
      checks++; if (pc_cp0 !== 30'h80) begin errors++; $display("FAIL mtc0_eret_pc got %h exp 80", pc_cp0); end
      checks++; if (cp0_forward !== 2'b01) begin errors++; $display("FAIL mtc0_eret_fwd got %b exp 01", cp0_forward); end
      tick();
      drive(1, 0, 5'd0, 0, 1, 5'd7, 32'hFFFF_FFFF, 30'd0);
      #1 tick();
      drive(0, 0, 5'd0, 0, 0, 5'd15, 32'd0, 30'd0);
      #1;
      checks++; if (cp0_rdata !== PRID) begin errors++; $display("FAIL prid got %h exp %h", cp0_rdata, PRID); end
      cp0_addr = 5'd7; #1;
      checks++; if (cp0_rdata !== 32'd0) begin errors++; $display("FAIL reg7 got %h exp 0", cp0_rdata); end
   endtask

   task automatic test_random();
      logic [4:0] addrs [6];
      addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7, 5'd0};
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(5) == 0) hw_int = 6'($urandom);
         drive($urandom_range(3) != 0, $urandom_range(7) == 0, 5'($urandom),
               $urandom_range(3) == 0, $urandom_range(3) == 0,
               ($urandom_range(5) == 5) ? 5'($urandom) : addrs[$urandom_range(4)],
               $urandom, 30'($urandom));
         #1;
         checks++; if (cp0_forward !== m_fwd()) begin errors++; $display("FAIL rnd_fwd n=%0d got %b exp %b", n, cp0_forward, m_fwd()); end
         checks++; if (pc_cp0 !== m_epc[31:2]) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, pc_cp0, m_epc[31:2]); end
         checks++; if (exl !== m_exl) begin errors++; $display("FAIL rnd_exl n=%0d got %b exp %b", n, exl, m_exl); end
         checks++; if (cp0_rdata !== m_read(cp0_addr)) begin errors++; $display("FAIL rnd_rdata n=%0d addr %0d got %h exp %h", n, cp0_addr, cp0_rdata, m_read(cp0_addr)); end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_exception();
      test_interrupt();
      test_eret();
      test_exc_priority();
      test_mtc0_eret();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
